// File: rtl/mux4_pkg.sv
// Shared definitions for the 4-channel round-robin mux select block.
// Holds the FSM state encoding, the channel count and select width, and
// small helper functions used by the select logic.
package mux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot decode of a channel index.
    function automatic logic [NUM_CH-1:0] onehot_ch(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = {NUM_CH{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Channel following idx, wrapping 3 -> 0 through the natural 2-bit overflow.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Stateless round-robin picker for four requesters.
// Ports:
//   req   - per-channel request vector
//   ptr   - channel that has first priority
//   found - at least one request is present
//   idx   - first requesting channel at or after ptr (modulo 4)
module rr_pick4
    import mux4_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [SEL_W-1:0] ch_s;

    // Scan from the farthest offset back to ptr so the nearest requester wins last.
    always_comb begin
        found = 1'b0;
        idx   = 2'b00;
        ch_s  = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            ch_s  = ptr + SEL_W'(k);
            found = found | req[ch_s];
            idx   = req[ch_s] ? ch_s : idx;
        end
    end

endmodule

// File: rtl/mux4_rr_sel.sv
// Round-robin select generator for a downstream 4:1 mux.
// A grant is issued one cycle after a request seen in IDLE and is held until
// the owner signals done, drops its request, or the hold limit expires.
// Every release is followed by at least one idle cycle.
// Parameter:
//   MAX_HOLD - maximum number of cycles one grant is held (legal 1..15)
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   req     - per-channel request
//   done    - current owner finished (looked at only while busy)
//   sel     - registered mux select, keeps last value while idle
//   grant   - registered one-hot grant, zero when idle
//   busy    - a grant is active
//   timeout - one-cycle pulse after a release caused only by the hold limit
module mux4_rr_sel
    import mux4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] grant,
    output logic              busy,
    output logic              timeout
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t            state_r, state_nxt_s;
    logic [SEL_W-1:0]  ptr_r, ptr_nxt_s;
    logic [3:0]        hold_cnt_r, hold_cnt_nxt_s;
    logic [SEL_W-1:0]  sel_r, sel_nxt_s;
    logic [NUM_CH-1:0] grant_r, grant_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              timeout_r, timeout_nxt_s;

    logic              found_s;
    logic [SEL_W-1:0]  pick_s;
    logic              owner_req_s;
    logic              hold_limit_s;
    logic              release_s;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .found (found_s),
        .idx   (pick_s)
    );

    assign owner_req_s  = req[sel_r];
    assign hold_limit_s = (hold_cnt_r == HOLD_LAST);
    assign release_s    = done | ~owner_req_s | hold_limit_s;

    // Next-state and next-output logic for the IDLE/BUSY arbiter.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        hold_cnt_nxt_s = hold_cnt_r;
        sel_nxt_s      = sel_r;
        grant_nxt_s    = grant_r;
        busy_nxt_s     = busy_r;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nxt_s    = BUSY;
                    sel_nxt_s      = pick_s;
                    grant_nxt_s    = onehot_ch(pick_s);
                    busy_nxt_s     = 1'b1;
                    hold_cnt_nxt_s = 4'd0;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            BUSY: begin
                if (release_s) begin
                    state_nxt_s    = IDLE;
                    grant_nxt_s    = {NUM_CH{1'b0}};
                    busy_nxt_s     = 1'b0;
                    hold_cnt_nxt_s = 4'd0;
                    ptr_nxt_s      = next_ch(sel_r);
                    // Only a pure hold-limit release flags a timeout; done wins a tie.
                    timeout_nxt_s  = ~done & owner_req_s;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 4'd1;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                grant_nxt_s    = {NUM_CH{1'b0}};
                busy_nxt_s     = 1'b0;
                hold_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= 2'b00;
            hold_cnt_r <= 4'd0;
            sel_r      <= 2'b00;
            grant_r    <= 4'b0000;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            sel_r      <= sel_nxt_s;
            grant_r    <= grant_nxt_s;
            busy_r     <= busy_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

    assign sel     = sel_r;
    assign grant   = grant_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_mux4_rr_sel.sv
module tb_mux4_rr_sel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;

    logic [1:0] sel_o     [3];
    logic [3:0] grant_o   [3];
    logic       busy_o    [3];
    logic       timeout_o [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one entry per instance (hold limits 8, 4, 1).
    int hold_of [3] = '{8, 4, 1};
    bit m_busy  [3];
    bit m_to    [3];
    int m_owner [3];
    int m_age   [3];
    int m_ptr   [3];

    always #5 clk = ~clk;

    mux4_rr_sel #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_o[0]), .grant(grant_o[0]), .busy(busy_o[0]), .timeout(timeout_o[0])
    );
    mux4_rr_sel #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_o[1]), .grant(grant_o[1]), .busy(busy_o[1]), .timeout(timeout_o[1])
    );
    mux4_rr_sel #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel_o[2]), .grant(grant_o[2]), .busy(busy_o[2]), .timeout(timeout_o[2])
    );

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_busy[m] = 1'b0; m_to[m] = 1'b0;
            m_owner[m] = 0; m_age[m] = 0; m_ptr[m] = 0;
        end
    endtask

    // Advance the model by one clock edge using the current req/done.
    task automatic model_edge();
        for (int m = 0; m < 3; m++) begin
            if (m_busy[m]) begin
                m_age[m] = m_age[m] + 1;
                if (done || !req[m_owner[m]] || m_age[m] >= hold_of[m]) begin
                    m_to[m]   = !done && req[m_owner[m]];
                    m_busy[m] = 1'b0;
                    m_ptr[m]  = (m_owner[m] + 1) % 4;
                end
            end else begin
                m_to[m] = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!m_busy[m] && req[(m_ptr[m] + k) % 4]) begin
                        m_busy[m]  = 1'b1;
                        m_owner[m] = (m_ptr[m] + k) % 4;
                        m_age[m]   = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(); else model_reset();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0000; done = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b0000; done = 1'b0;
        model_reset();
        repeat (3) tick();
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if ({grant_o[m], sel_o[m], busy_o[m], timeout_o[m]} !== 8'b0000_00_0_0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got %b want %b", m,
                         {grant_o[m], sel_o[m], busy_o[m], timeout_o[m]}, 8'b0000_00_0_0);
            end
        end
        rst_n = 1'b1; req = 4'b0100;
        tick();
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if ({grant_o[m], sel_o[m], busy_o[m], timeout_o[m]} !== 8'b0100_10_1_0) begin
                n_fail++;
                $display("FAIL first_grant dut%0d: got %b want %b", m,
                         {grant_o[m], sel_o[m], busy_o[m], timeout_o[m]}, 8'b0100_10_1_0);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_s = 2'(g % 4);
            exp_g = 4'b0001 << (g % 4);
            tick();
            n_checks++;
            if ({grant_o[0], sel_o[0], busy_o[0], timeout_o[0]} !== {exp_g, exp_s, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL rotation_grant g%0d: got %b want %b", g,
                         {grant_o[0], sel_o[0], busy_o[0], timeout_o[0]}, {exp_g, exp_s, 1'b1, 1'b0});
            end
            tick();
            n_checks++;
            if ({grant_o[0], sel_o[0], busy_o[0]} !== {exp_g, exp_s, 1'b1}) begin
                n_fail++;
                $display("FAIL rotation_hold g%0d: got %b want %b", g,
                         {grant_o[0], sel_o[0], busy_o[0]}, {exp_g, exp_s, 1'b1});
            end
            done = 1'b1;
            tick();
            n_checks++;
            if ({grant_o[0], sel_o[0], busy_o[0], timeout_o[0]} !== {4'b0000, exp_s, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rotation_idle g%0d: got %b want %b", g,
                         {grant_o[0], sel_o[0], busy_o[0], timeout_o[0]}, {4'b0000, exp_s, 1'b0, 1'b0});
            end
            done = 1'b0;
        end
    endtask

    task automatic test_hold_limit();
        int cnt;
        do_reset();
        req = 4'b0010;
        cnt = 0;
        tick();
        while (busy_o[0] === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        n_checks++;
        if (cnt != 8) begin
            n_fail++;
            $display("FAIL hold_length: got %0d cycles want 8", cnt);
        end
        n_checks++;
        if ({grant_o[0], timeout_o[0]} !== 5'b0000_1) begin
            n_fail++;
            $display("FAIL hold_timeout: got %b want %b", {grant_o[0], timeout_o[0]}, 5'b0000_1);
        end
        req = 4'b1110;
        tick();
        n_checks++;
        if ({grant_o[0], sel_o[0], timeout_o[0]} !== 7'b0100_10_0) begin
            n_fail++;
            $display("FAIL hold_ptr_next: got %b want %b", {grant_o[0], sel_o[0], timeout_o[0]}, 7'b0100_10_0);
        end
    endtask

    task automatic test_single_cycle();
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        n_checks++;
        if ({grant_o[2], busy_o[2], timeout_o[2]} !== 6'b0000_0_1) begin
            n_fail++;
            $display("FAIL one_cycle_release: got %b want %b", {grant_o[2], busy_o[2], timeout_o[2]}, 6'b0000_0_1);
        end
        tick();
        n_checks++;
        if ({grant_o[2], busy_o[2], timeout_o[2]} !== 6'b0100_1_0) begin
            n_fail++;
            $display("FAIL one_cycle_regrant: got %b want %b", {grant_o[2], busy_o[2], timeout_o[2]}, 6'b0100_1_0);
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 4'b1000;
        repeat (3) tick();
        n_checks++;
        if ({grant_o[0], sel_o[0], busy_o[0]} !== 7'b1000_11_1) begin
            n_fail++;
            $display("FAIL drop_owner: got %b want %b", {grant_o[0], sel_o[0], busy_o[0]}, 7'b1000_11_1);
        end
        req = 4'b0111;
        tick();
        n_checks++;
        if ({grant_o[0], sel_o[0], busy_o[0], timeout_o[0]} !== 8'b0000_11_0_0) begin
            n_fail++;
            $display("FAIL drop_release: got %b want %b",
                     {grant_o[0], sel_o[0], busy_o[0], timeout_o[0]}, 8'b0000_11_0_0);
        end
        req = 4'b1001;
        tick();
        n_checks++;
        if ({grant_o[0], sel_o[0]} !== 6'b0001_00) begin
            n_fail++;
            $display("FAIL drop_ptr_wrap: got %b want %b", {grant_o[0], sel_o[0]}, 6'b0001_00);
        end
    endtask

    task automatic test_done_at_limit();
        do_reset();
        req = 4'b0001;
        repeat (4) tick();
        n_checks++;
        if ({grant_o[1], busy_o[1]} !== 5'b0001_1) begin
            n_fail++;
            $display("FAIL limit_cycle4: got %b want %b", {grant_o[1], busy_o[1]}, 5'b0001_1);
        end
        done = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if ({grant_o[m], busy_o[m], timeout_o[m]} !== 6'b0000_0_0) begin
                n_fail++;
                $display("FAIL done_priority dut%0d: got %b want %b", m,
                         {grant_o[m], busy_o[m], timeout_o[m]}, 6'b0000_0_0);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010;
        tick();
        n_checks++;
        if ({grant_o[0], sel_o[0], busy_o[0]} !== 7'b0010_01_1) begin
            n_fail++;
            $display("FAIL arst_pre: got %b want %b", {grant_o[0], sel_o[0], busy_o[0]}, 7'b0010_01_1);
        end
        #3;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if ({grant_o[m], sel_o[m], busy_o[m], timeout_o[m]} !== 8'b0000_00_0_0) begin
                n_fail++;
                $display("FAIL arst_drop dut%0d: got %b want %b", m,
                         {grant_o[m], sel_o[m], busy_o[m], timeout_o[m]}, 8'b0000_00_0_0);
            end
        end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        req = 4'b0011;
        tick();
        n_checks++;
        if ({grant_o[0], sel_o[0], timeout_o[0]} !== 7'b0001_00_0) begin
            n_fail++;
            $display("FAIL arst_next_grant: got %b want %b", {grant_o[0], sel_o[0], timeout_o[0]}, 7'b0001_00_0);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 4) == 0);
            tick();
            for (int m = 0; m < 3; m++) begin
                exp_g = m_busy[m] ? (4'b0001 << m_owner[m]) : 4'b0000;
                n_checks++;
                if ({grant_o[m], sel_o[m], busy_o[m], timeout_o[m]} !==
                    {exp_g, 2'(m_owner[m]), m_busy[m], m_to[m]}) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: got %b want %b", m, i,
                             {grant_o[m], sel_o[m], busy_o[m], timeout_o[m]},
                             {exp_g, 2'(m_owner[m]), m_busy[m], m_to[m]});
                end
            end
        end
        done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_hold_limit();
        test_single_cycle();
        test_req_drop();
        test_done_at_limit();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mux4_rr_sel.md
MUX4_RR_SEL -- requirements
Module: mux4_rr_sel

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 8, legal range 1..15, giving the maximum number of cycles one grant is held.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req, input, 4 bits: per-channel request; bit i asks for mux input i.
REQ-005 The block SHALL have port done, input, 1 bit: the current owner has finished; sampled only while busy.
REQ-006 The block SHALL have port sel, output, 2 bits: registered select driven to the downstream 4:1 mux sel input.
REQ-007 The block SHALL have port grant, output, 4 bits: registered one-hot grant; all zero when not busy.
REQ-008 The block SHALL have port busy, output, 1 bit: high while any grant is active.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-011 In IDLE with req != 0, the block SHALL select the first asserted req bit, searching from pointer ptr upward modulo 4.
REQ-012 In that IDLE case, the block SHALL enter BUSY on the next edge with grant = one-hot(selected), sel = selected index, busy = 1 and hold_cnt = 0, giving 1-cycle latency from request to grant.
REQ-013 In IDLE with req == 0, all outputs SHALL hold; sel SHALL keep its last value.
REQ-014 In BUSY, grant and sel SHALL stay stable, and hold_cnt SHALL increment by 1 each cycle.
REQ-015 In BUSY, a release SHALL occur at the edge ending any cycle in which done == 1, or req[sel] == 0, or hold_cnt == MAX_HOLD-1.
REQ-016 On release, the block SHALL return to IDLE with grant = 0 and busy = 0, and set ptr = (sel+1) mod 4 (wrap 3 -> 0).
REQ-017 After every release, at least one cycle SHALL pass with grant = 0 before the next grant.
REQ-018 timeout SHALL be 1 for exactly the cycle after a release caused only by the hold limit, that is with done == 0 and req[sel] == 1.
REQ-019 When done coincides with the hold limit, done SHALL take priority and timeout SHALL stay 0.
REQ-020 The block SHALL ignore changes on req bits other than sel while BUSY; arbitration happens only in IDLE.
REQ-021 With MAX_HOLD = 1, every grant SHALL last exactly one cycle.
REQ-022 The block SHALL keep hold_cnt 4 bits wide, and it SHALL never wrap within a grant.

Reset
REQ-023 rst_n low SHALL immediately force state = IDLE, ptr = 0, hold_cnt = 0, sel = 2'b00, grant = 4'b0000, busy = 0 and timeout = 0, independent of clk.
REQ-024 A reset asserted mid-grant SHALL drop grant at once, with no timeout pulse and no ptr update.
REQ-025 After rst_n deasserts, the first grant SHALL follow the REQ-011 search starting at channel 0.

Structure
REQ-026 A shared package mux4_pkg SHALL hold the FSM state encoding (IDLE = 0, BUSY = 1), the channel-count constant 4 and the sel width constant 2.
REQ-027 The block SHALL use one combinational sub-module, rr_pick4, that takes (req, ptr) and returns (found, idx); it SHALL contain no state.
REQ-028 sel SHALL connect directly to the existing 4:1 mux select, so the mux output equals in[sel] whenever busy = 1.

Verification
REQ-029 The bench SHALL drive rst_n low for 3 cycles, then high with req = 4'b0100; grant = 4'b0100 and sel = 2 SHALL appear 1 cycle later.
REQ-030 The bench SHALL hold req = 4'b1111 with done pulsed on the 2nd busy cycle of each grant; sel SHALL cycle 0, 1, 2, 3, 0 with one idle cycle between grants.
REQ-031 With MAX_HOLD = 8, req = 4'b0010 held and done = 0, the grant SHALL last exactly 8 cycles, then timeout SHALL pulse for 1 cycle and ptr SHALL become 2.
REQ-032 With the owner on channel 3 and req[3] dropped on busy cycle 3, the grant SHALL be released at the next edge, ptr SHALL become 0, and timeout SHALL stay 0.
REQ-033 The bench SHALL assert done on the same cycle as the hold limit (MAX_HOLD = 4, done on busy cycle 4); the block SHALL release with timeout = 0.
REQ-034 The bench SHALL assert rst_n low asynchronously (between edges) during a grant on channel 1; grant, sel and busy SHALL go to 0 before the next edge, and the next grant with req = 4'b0011 SHALL be channel 0.
